// File: rtl/fifo_queue_pkg.sv
// Shared constants and width helpers for the fifo_queue block.
//   DefDataCount / DefDataWidth : default depth and word width
//   count_width(n)              : bits needed to hold a fill count 0..n
//   ptr_width(n)                : bits needed to index 0..n-1, never less than 1
package fifo_queue_pkg;

    localparam int unsigned DefDataCount = 3;
    localparam int unsigned DefDataWidth = 16;

    function automatic int unsigned count_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    function automatic int unsigned ptr_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Circular pointer for fifo_queue: counts 0..data_count-1 and wraps by explicit
// compare, so depths that are not powers of two work.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset, pointer returns to 0
//   advance : step the pointer by one on this edge
//   ptr     : current pointer value
module fifo_ptr_wrap
    import fifo_queue_pkg::*;
#(
    parameter int unsigned data_count = DefDataCount
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            advance,
    output logic [ptr_width(data_count)-1:0] ptr
);

    localparam int unsigned PtrW = ptr_width(data_count);

    logic [PtrW-1:0] r_ptr;
    logic [PtrW-1:0] w_ptr_d;

    always_comb begin
        w_ptr_d = r_ptr;
        if (advance) begin
            if (r_ptr == PtrW'(data_count - 1)) begin
                w_ptr_d = '0;
            end else begin
                w_ptr_d = r_ptr + PtrW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_d;
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/fifo_queue.sv
// Circular-buffer FIFO with fill count, overflow/underflow pulses and a
// registered read port.
//   clock, reset_n     : rising-edge clock, asynchronous active-low reset
//   push, data_in      : enqueue request and word
//   pop                : dequeue request
//   data_out           : word dequeued on the previous edge (0 after a rejected pop)
//   data_valid         : data_out carries a word dequeued on the previous edge
//   empty, full, count : fill state decoded from the registered count
//   overflow/underflow : one-cycle pulse per rejected push/pop
module fifo_queue
    import fifo_queue_pkg::*;
#(
    parameter int unsigned data_count = DefDataCount,
    parameter int unsigned data_width = DefDataWidth
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              push,
    input  logic                              pop,
    input  logic [data_width-1:0]             data_in,
    output logic [data_width-1:0]             data_out,
    output logic                              data_valid,
    output logic                              empty,
    output logic                              full,
    output logic [count_width(data_count)-1:0] count,
    output logic                              overflow,
    output logic                              underflow
);

    localparam int unsigned CntW = count_width(data_count);
    localparam int unsigned PtrW = ptr_width(data_count);

    logic [data_width-1:0] r_mem [data_count];
    logic [CntW-1:0]       r_count;
    logic [CntW-1:0]       w_count_d;
    logic [PtrW-1:0]       w_wr_ptr;
    logic [PtrW-1:0]       w_rd_ptr;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_push_ok;
    logic                  w_pop_ok;
    logic [data_width-1:0] r_data_out;
    logic                  r_data_valid;
    logic                  r_overflow;
    logic                  r_underflow;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CntW'(data_count));

    // A pop at full frees the slot being written, so the push is still taken.
    assign w_push_ok = push && (!w_full || pop);
    assign w_pop_ok  = pop && !w_empty;

    always_comb begin
        w_count_d = r_count;
        if (w_push_ok && !w_pop_ok) begin
            w_count_d = r_count + CntW'(1);
        end else if (!w_push_ok && w_pop_ok) begin
            w_count_d = r_count - CntW'(1);
        end
    end

    fifo_ptr_wrap #(
        .data_count(data_count)
    ) u_wr_ptr (
        .clock  (clock),
        .reset_n(reset_n),
        .advance(w_push_ok),
        .ptr    (w_wr_ptr)
    );

    fifo_ptr_wrap #(
        .data_count(data_count)
    ) u_rd_ptr (
        .clock  (clock),
        .reset_n(reset_n),
        .advance(w_pop_ok),
        .ptr    (w_rd_ptr)
    );

    // Storage is not reset; contents are meaningless until written.
    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_mem[w_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count      <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_count      <= w_count_d;
            r_data_valid <= w_pop_ok;
            r_overflow   <= push && w_full && !pop;
            r_underflow  <= pop && w_empty;
            // Old mem[rd_ptr] is read even when the same slot is written this edge.
            if (w_pop_ok) begin
                r_data_out <= r_mem[w_rd_ptr];
            end else if (pop) begin
                r_data_out <= '0;
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign empty      = w_empty;
    assign full       = w_full;
    assign count      = r_count;
    assign overflow   = r_overflow;
    assign underflow  = r_underflow;

endmodule

// File: tb/tb_fifo_queue.sv
module tb_fifo_queue;

    localparam int unsigned Depth = 3;
    localparam int unsigned Width = 16;
    localparam int unsigned CntW  = $clog2(Depth + 1);

    logic             clock;
    logic             reset_n;
    logic             push;
    logic             pop;
    logic [Width-1:0] data_in;
    logic [Width-1:0] data_out;
    logic             data_valid;
    logic             empty;
    logic             full;
    logic [CntW-1:0]  count;
    logic             overflow;
    logic             underflow;

    fifo_queue #(
        .data_count(Depth),
        .data_width(Width)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .pop       (pop),
        .data_in   (data_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_bad    = 0;

    // Reference model: an ordered list of stored words plus the last read result.
    logic [Width-1:0] m_q [$];
    logic [Width-1:0] m_dout;
    logic             m_valid;
    logic             m_ovf;
    logic             m_unf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"}, 32'(count), 32'(m_q.size()));
        check({tag, ".empty"}, 32'(empty), 32'(m_q.size() == 0));
        check({tag, ".full"}, 32'(full), 32'(m_q.size() == Depth));
        check({tag, ".data_valid"}, 32'(data_valid), 32'(m_valid));
        check({tag, ".data_out"}, 32'(data_out), 32'(m_dout));
        check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        check({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
    endtask

    // One clock cycle with the given request; outputs checked 1 time unit after the edge.
    task automatic do_cycle(input string tag, input logic p, input logic o,
                            input logic [Width-1:0] d);
        bit was_full;
        bit was_empty;
        push    = p;
        pop     = o;
        data_in = d;
        @(posedge clock);
        #1;
        was_full  = (m_q.size() == Depth);
        was_empty = (m_q.size() == 0);
        m_valid = 1'b0;
        m_ovf   = p && was_full && !o;
        m_unf   = o && was_empty;
        if (o && !was_empty) begin
            m_dout  = m_q.pop_front();
            m_valid = 1'b1;
        end else if (o) begin
            m_dout = '0;
        end
        if (p && (!was_full || o)) begin
            m_q.push_back(d);
        end
        check_all(tag);
        push = 1'b0;
        pop  = 1'b0;
    endtask

    initial begin
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
        reset_n = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clock);
        reset_n = 1'b1;

        // FIFO order
        do_cycle("order_push", 1'b1, 1'b0, 16'h1111);
        do_cycle("order_push", 1'b1, 1'b0, 16'h2222);
        do_cycle("order_push", 1'b1, 1'b0, 16'h3333);
        check("order_full", 32'(full), 32'd1);
        do_cycle("order_pop", 1'b0, 1'b1, 16'h0);
        check("order_first", 32'(data_out), 32'h1111);
        do_cycle("order_pop", 1'b0, 1'b1, 16'h0);
        do_cycle("order_pop", 1'b0, 1'b1, 16'h0);
        check("order_last", 32'(data_out), 32'h3333);
        check("order_empty", 32'(empty), 32'd1);

        // Overflow, drain, underflow
        do_cycle("ovf_fill", 1'b1, 1'b0, 16'h1111);
        do_cycle("ovf_fill", 1'b1, 1'b0, 16'h2222);
        do_cycle("ovf_fill", 1'b1, 1'b0, 16'h3333);
        do_cycle("ovf_push", 1'b1, 1'b0, 16'h4444);
        check("ovf_pulse", 32'(overflow), 32'd1);
        do_cycle("ovf_drop", 1'b0, 1'b1, 16'h0);
        check("ovf_drop_val", 32'(overflow), 32'd0);
        do_cycle("ovf_drain", 1'b0, 1'b1, 16'h0);
        do_cycle("ovf_drain", 1'b0, 1'b1, 16'h0);
        check("ovf_drain_last", 32'(data_out), 32'h3333);
        do_cycle("unf_pop", 1'b0, 1'b1, 16'h0);
        check("unf_pulse", 32'(underflow), 32'd1);
        do_cycle("unf_pop2", 1'b0, 1'b1, 16'h0);
        do_cycle("unf_idle", 1'b0, 1'b0, 16'h0);

        // Wrap-around
        do_cycle("wrap_push", 1'b1, 1'b0, 16'hAAAA);
        do_cycle("wrap_pop", 1'b0, 1'b1, 16'h0);
        do_cycle("wrap_push", 1'b1, 1'b0, 16'hBBBB);
        do_cycle("wrap_push", 1'b1, 1'b0, 16'hCCCC);
        do_cycle("wrap_push", 1'b1, 1'b0, 16'hDDDD);
        do_cycle("wrap_pop", 1'b0, 1'b1, 16'h0);
        check("wrap_first", 32'(data_out), 32'hBBBB);
        do_cycle("wrap_pop", 1'b0, 1'b1, 16'h0);
        do_cycle("wrap_pop", 1'b0, 1'b1, 16'h0);

        // Simultaneous push/pop at full, then at empty
        do_cycle("sim_fill", 1'b1, 1'b0, 16'h1111);
        do_cycle("sim_fill", 1'b1, 1'b0, 16'h2222);
        do_cycle("sim_fill", 1'b1, 1'b0, 16'h3333);
        do_cycle("sim_full", 1'b1, 1'b1, 16'h5555);
        check("sim_full_out", 32'(data_out), 32'h1111);
        do_cycle("sim_drain", 1'b0, 1'b1, 16'h0);
        do_cycle("sim_drain", 1'b0, 1'b1, 16'h0);
        do_cycle("sim_drain", 1'b0, 1'b1, 16'h0);
        check("sim_drain_last", 32'(data_out), 32'h5555);
        do_cycle("sim_empty", 1'b1, 1'b1, 16'h7777);
        check("sim_empty_cnt", 32'(count), 32'd1);
        do_cycle("sim_empty_pop", 1'b0, 1'b1, 16'h0);
        check("sim_empty_out", 32'(data_out), 32'h7777);

        // Reset between edges with two entries stored
        do_cycle("rst_push", 1'b1, 1'b0, 16'h0101);
        do_cycle("rst_push", 1'b1, 1'b1, 16'h0202);
        do_cycle("rst_push", 1'b1, 1'b0, 16'h0303);
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_mid");
        @(negedge clock);
        reset_n = 1'b1;
        do_cycle("rst_after_pop", 1'b0, 1'b1, 16'h0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            do_cycle("rand", 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
                     16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
